// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with a stateful accumulator and a 2-entry
// in-order result buffer behind a valid/ready handshake on both sides.
module logic_unit_pipe #(
  parameter int unsigned           WIDTH   = 32,
  parameter logic [WIDTH-1:0]      ACC_RST = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] rd_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] acc_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res;
  logic             accept;
  logic             deliver;

  // Handshake flags depend only on registered state, never on ready_i/valid_i.
  assign ready_o = (state_q != TWO);
  assign valid_o = (state_q != EMPTY);
  assign accept  = valid_i & ready_o;
  assign deliver = valid_o & ready_i;

  assign rd_o   = head_q;
  assign zero_o = valid_o & (head_q == '0);
  assign acc_o  = acc_q;

  always_comb begin
    res = '0;
    case (op_i)
      3'b000:  res = rs1_i & rs2_i;
      3'b001:  res = rs1_i | rs2_i;
      3'b010:  res = rs1_i ^ rs2_i;
      3'b011:  res = rs1_i & ~rs2_i;
      3'b100:  res = acc_q & rs1_i;
      3'b101:  res = acc_q | rs1_i;
      3'b110:  res = acc_q ^ rs1_i;
      default: res = rs1_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    acc_d   = (accept && op_i[2]) ? res : acc_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = res;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          head_d = res;
        end else if (accept) begin
          tail_d  = res;
          state_d = TWO;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Tail is promoted straight to the head so a valid head never bubbles.
        if (deliver) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      acc_q   <= ACC_RST;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe with scoreboarded random
// handshake traffic and width-parametrised instances.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_i;
  logic        ready_o, valid_o, zero_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i, rd_o, acc_o;

  logic        valid_p, ready_p;
  logic [2:0]  op_p;
  logic        rs1_1, rs2_1, rd_1, acc_1, ready_1, valid_1, zero_1;
  logic [63:0] rs1_64, rs2_64, rd_64, acc_64;
  logic        ready_64, valid_64, zero_64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_unit_pipe dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .valid_o(valid_o),
    .ready_i(ready_i), .rd_o(rd_o), .zero_o(zero_o), .acc_o(acc_o)
  );

  logic_unit_pipe #(.WIDTH(1), .ACC_RST(1'b1)) u_w1 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_p), .ready_o(ready_1),
    .op_i(op_p), .rs1_i(rs1_1), .rs2_i(rs2_1), .valid_o(valid_1),
    .ready_i(ready_p), .rd_o(rd_1), .zero_o(zero_1), .acc_o(acc_1)
  );

  logic_unit_pipe #(.WIDTH(64), .ACC_RST({64{1'b1}})) u_w64 (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_p), .ready_o(ready_64),
    .op_i(op_p), .rs1_i(rs1_64), .rs2_i(rs2_64), .valid_o(valid_64),
    .ready_i(ready_p), .rd_o(rd_64), .zero_o(zero_64), .acc_o(acc_64)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic        zero;
    logic [31:0] acc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] acc);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a & ~b;
      3'd4: return acc & a;
      3'd5: return acc | a;
      3'd6: return acc ^ a;
      default: return a;
    endcase
  endfunction

  initial begin
    logic [31:0] q[$];
    logic [31:0] m_acc, exp_rd, res;
    logic        r, m_ready, m_deliver;
    int          accepted, cycles;

    vecs[0]  = '{3'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0, 32'h0};
    vecs[1]  = '{3'd1, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0, 1'b0, 32'h0};
    vecs[2]  = '{3'd2, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0, 1'b0, 32'h0};
    vecs[3]  = '{3'd3, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hF000_0F00, 1'b0, 32'h0};
    vecs[4]  = '{3'd3, 32'h0000_000F, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0};
    vecs[5]  = '{3'd7, 32'hFFFF_FFFF, 32'h1111_1111, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd4, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[7]  = '{3'd5, 32'h0000_0001, 32'h0000_0000, 32'h1234_5679, 1'b0, 32'h1234_5679};
    vecs[8]  = '{3'd6, 32'h1234_5679, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[9]  = '{3'd0, 32'hFFFF_0000, 32'h00FF_FF00, 32'h00FF_0000, 1'b0, 32'h0};
    vecs[10] = '{3'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0};

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    valid_p = 1'b0; ready_p = 1'b0; op_p = '0;
    rs1_1 = 1'b0; rs2_1 = 1'b0; rs1_64 = '0; rs2_64 = '0;
    tick(); tick();
    check("rst_valid", valid_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_zero", zero_o, 0);
    check("rst_acc", acc_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_acc_w1", acc_1, 1);
    check("rst_acc_w64", acc_64, 64'hFFFF_FFFF_FFFF_FFFF);
    rst_ni = 1'b1;

    // Table: back-to-back accepts with ready_i held high.
    ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      valid_i = 1'b1; op_i = vecs[i].op; rs1_i = vecs[i].rs1; rs2_i = vecs[i].rs2;
      tick();
      check($sformatf("vec%0d_valid", i), valid_o, 1);
      check($sformatf("vec%0d_rd", i), rd_o, vecs[i].rd);
      check($sformatf("vec%0d_zero", i), zero_o, vecs[i].zero);
      check($sformatf("vec%0d_acc", i), acc_o, vecs[i].acc);
    end
    valid_i = 1'b0;
    tick();
    check("drain_empty", valid_o, 0);

    // Backpressure: three offered ops, two accepted, ordered drain.
    ready_i = 1'b0; valid_i = 1'b1; op_i = 3'd0; rs2_i = 32'hFFFF_FFFF;
    rs1_i = 32'h11;
    tick();
    check("bp1_rd", rd_o, 32'h11);
    check("bp1_ready", ready_o, 1);
    rs1_i = 32'h22;
    tick();
    check("bp2_ready", ready_o, 0);
    check("bp2_rd", rd_o, 32'h11);
    rs1_i = 32'h33;
    tick();
    check("bp3_ready", ready_o, 0);
    check("bp3_rd_hold", rd_o, 32'h11);
    check("bp3_valid", valid_o, 1);
    ready_i = 1'b1;
    tick();
    check("bp4_rd", rd_o, 32'h22);
    check("bp4_ready", ready_o, 1);
    tick();
    check("bp5_rd", rd_o, 32'h33);
    valid_i = 1'b0;
    tick();
    check("bp6_empty", valid_o, 0);

    // Width parametrisation: ANDN all-ones/0, then ACC_AND 0 against all-ones reset acc.
    valid_p = 1'b1; ready_p = 1'b1; op_p = 3'd3;
    rs1_1 = 1'b1; rs2_1 = 1'b0; rs1_64 = {64{1'b1}}; rs2_64 = '0;
    tick();
    check("w1_andn", rd_1, 1);
    check("w64_andn", rd_64, 64'hFFFF_FFFF_FFFF_FFFF);
    op_p = 3'd4; rs1_1 = 1'b0; rs1_64 = '0;
    tick();
    check("w1_accand", rd_1, 0);
    check("w1_accand_zero", zero_1, 1);
    check("w1_acc", acc_1, 0);
    check("w64_accand", rd_64, 0);
    check("w64_accand_zero", zero_64, 1);
    check("w64_acc", acc_64, 0);
    valid_p = 1'b0;

    // Reset with the buffer full and acc = 0xDEADBEEF.
    ready_i = 1'b0; valid_i = 1'b1; op_i = 3'd7; rs1_i = 32'hDEAD_BEEF;
    tick();
    op_i = 3'd5; rs1_i = 32'h0;
    tick();
    check("full_ready", ready_o, 0);
    check("full_acc", acc_o, 32'hDEAD_BEEF);
    rst_ni = 1'b0; op_i = 3'd7; rs1_i = 32'h55;
    tick();
    check("mrst_valid", valid_o, 0);
    check("mrst_acc", acc_o, 0);
    check("mrst_ready", ready_o, 1);
    check("mrst_rd", rd_o, 0);
    rst_ni = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_stale", valid_o, 0);
    end
    // Accept offered on the reset edge must be discarded.
    rst_ni = 1'b0; valid_i = 1'b1; op_i = 3'd7; rs1_i = 32'h77;
    tick();
    rst_ni = 1'b1; valid_i = 1'b0;
    check("rst_accept_valid", valid_o, 0);
    check("rst_accept_acc", acc_o, 0);
    tick();
    check("rst_accept_later", valid_o, 0);

    // Random handshake traffic against a scoreboard.
    m_acc = '0; accepted = 0; cycles = 0;
    while (accepted < 1000 && cycles < 6000) begin
      cycles++;
      valid_i = ($urandom_range(0, 3) != 0);
      op_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
      r = 1'($urandom_range(0, 1));
      ready_i = ~r;
      #1;
      check("rnd_ready_comb", ready_o, (q.size() != 2));
      ready_i = r;
      #1;
      m_ready = (q.size() != 2);
      m_deliver = (q.size() != 0) && r;
      check("rnd_ready", ready_o, m_ready);
      check("rnd_valid", valid_o, (q.size() != 0));
      check("rnd_acc", acc_o, m_acc);
      if (m_deliver) begin
        exp_rd = q.pop_front();
        check("rnd_rd", rd_o, exp_rd);
        check("rnd_zero", zero_o, (exp_rd == 0));
      end
      if (valid_i && m_ready) begin
        res = model_op(op_i, rs1_i, rs2_i, m_acc);
        if (op_i[2]) m_acc = res;
        q.push_back(res);
        accepted++;
      end
      tick();
    end
    check("rnd_all_accepted", accepted, 1000);
    valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 4 && q.size() != 0; i++) begin
      check("drain_valid", valid_o, 1);
      exp_rd = q.pop_front();
      check("drain_rd", rd_o, exp_rd);
      tick();
    end
    check("drain_left", q.size(), 0);
    check("drain_final_valid", valid_o, 0);
    check("drain_final_acc", acc_o, m_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
